instr_reg_sched: RTL

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

---
 rtl/instr_register_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/instr_reg_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write scheduler.
package instr_register_pkg;

  localparam int unsigned DEPTH = 32;

  typedef logic signed [31:0] operand_t;
  typedef logic [$clog2(DEPTH)-1:0] address_t;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef struct packed {
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;
  } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the history bit advances only on an accepted grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // last_grant = 1 means requester 1 won last, so requester 0 wins the next tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Arbitrates two instruction writers into the instruction register and tracks
// its read/write pointers and occupancy.
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH = instr_register_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req0_valid,
  input  logic                     req1_valid,
  output logic                     req0_ready,
  output logic                     req1_ready,
  input  opcode_t                  req0_opcode,
  input  opcode_t                  req1_opcode,
  input  operand_t                 req0_operand_a,
  input  operand_t                 req0_operand_b,
  input  operand_t                 req1_operand_a,
  input  operand_t                 req1_operand_b,
  output logic                     load_en,
  output opcode_t                  opcode,
  output operand_t                 operand_a,
  output operand_t                 operand_b,
  output address_t                 write_pointer,
  output address_t                 read_pointer,
  output logic                     rd_valid,
  input  logic                     rd_pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  if (DEPTH != 2 ** $bits(address_t)) begin : g_depth_check
    $error("DEPTH must match the address_t range");
  end

  logic [1:0]      grant;
  logic            wr_accept;
  logic            pop_accept;
  address_t        wr_ptr_q;
  address_t        rd_ptr_q;
  logic [CntW-1:0] count_q;
  req_t            req0_data;
  req_t            req1_data;
  req_t            sel_data;

  rr_arbiter2 u_arbiter (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .accept (wr_accept),
    .grant  (grant)
  );

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign req0_ready = grant[0] & ~full & ~flush & ~reset;
  assign req1_ready = grant[1] & ~full & ~flush & ~reset;
  assign wr_accept  = req0_ready | req1_ready;
  assign load_en    = wr_accept;

  assign rd_valid   = ~empty;
  assign pop_accept = rd_pop & rd_valid & ~flush & ~reset;

  assign req0_data = '{opcode: req0_opcode, operand_a: req0_operand_a, operand_b: req0_operand_b};
  assign req1_data = '{opcode: req1_opcode, operand_a: req1_operand_a, operand_b: req1_operand_b};

  always_comb begin
    sel_data = '0;
    if (req0_ready) begin
      sel_data = req0_data;
    end else if (req1_ready) begin
      sel_data = req1_data;
    end
  end

  assign opcode    = sel_data.opcode;
  assign operand_a = sel_data.operand_a;
  assign operand_b = sel_data.operand_b;

  // Flush drops every queued entry by catching the reader up to the writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + address_t'(1);
      end
      if (pop_accept) begin
        rd_ptr_q <= rd_ptr_q + address_t'(1);
      end
      case ({wr_accept, pop_accept})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign write_pointer = wr_ptr_q;
  assign read_pointer  = rd_ptr_q;
  assign count         = count_q;

endmodule
